// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size codes, FSM states and latched request type
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between memory stage and data memory
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte/half lane merge for stores, extract/extend for loads, misalign detect
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [31:0] merged,
  output logic [31:0] load_data,
  output logic        err
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    merged    = mem_word;
    load_data = '0;
    err       = 1'b0;
    b_lane    = mem_word[{addr_lo, 3'b000} +: 8];
    h_lane    = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    case (size)
      SZ_BYTE: begin
        merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        load_data = sgn ? {{24{b_lane[7]}}, b_lane} : {24'b0, b_lane};
      end
      SZ_HALF: begin
        err = addr_lo[0];
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
        load_data = sgn ? {{16{h_lane[15]}}, h_lane} : {16'b0, h_lane};
      end
      SZ_WORD: begin
        err       = (addr_lo != 2'b00);
        merged    = wdata;
        load_data = mem_word;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-port data memory with fixed wait states and one-cycle response
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_e      state, state_nx;
  logic [2:0]  cnt;
  req_t        req_q, req_live, acc;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic        err_q;
  logic [AW-1:0] idx;
  logic [31:0] mem_word, merged, load_data;
  logic        lane_err, accept, enter_resp;
  logic        unused_addr_bits;

  assign req_live = {bus.req_we, bus.req_size, bus.req_signed, bus.req_addr, bus.req_wdata};
  assign accept   = (state == ST_IDLE) && bus.req_valid;
  // With zero wait states the access happens on the acceptance edge, so use the live request then.
  assign acc      = (state == ST_IDLE) ? req_live : req_q;
  assign idx      = acc.addr[AW+1:2];
  assign mem_word = mem[idx];
  assign unused_addr_bits = ^acc.addr[31:AW+2];

  dmem_lane_unit u_lane (
    .size      (acc.sz),
    .sgn       (acc.sgn),
    .addr_lo   (acc.addr[1:0]),
    .wdata     (acc.wdata),
    .mem_word  (mem_word),
    .merged    (merged),
    .load_data (load_data),
    .err       (lane_err)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.req_valid) state_nx = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == 3'd0) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign enter_resp = (state != ST_RESP) && (state_nx == ST_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_q <= req_live;
        cnt   <= CNT_LOAD;
      end else if (state == ST_WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (enter_resp) begin
        err_q   <= lane_err;
        rdata_q <= (acc.we || lane_err) ? 32'd0 : load_data;
      end
    end
  end

  // Array contents survive reset; a reset in WAIT returns to IDLE so no commit can follow.
  always_ff @(posedge clk) begin
    if (enter_resp && acc.we && !lane_err) mem[idx] <= merged;
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = (state == ST_RESP) ? rdata_q : 32'd0;
  assign bus.rsp_err   = (state == ST_RESP) && err_q;
  assign bus.stall     = bus.req_valid && (state != ST_RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed checks for wait-state, zero-wait, lanes, errors, reset and wrap
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  data_mem_responder_if b1 ();
  data_mem_responder_if b0 ();

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One request on the WAIT_CYCLES=1 instance; inputs are scrambled right after acceptance.
  task automatic txn1(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, b1.req_ready}, 32'd1);
    b1.req_valid = 1'b1; b1.req_we = we; b1.req_size = sz; b1.req_signed = sgn;
    b1.req_addr = addr; b1.req_wdata = wdata;
    @(posedge clk); #1;
    b1.req_valid = 1'b0; b1.req_we = ~we; b1.req_size = ~sz; b1.req_signed = ~sgn;
    b1.req_addr = ~addr; b1.req_wdata = ~wdata;
    lat = 0;
    while (!b1.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_rdata"}, b1.rsp_rdata, exp_rd);
    check({tag, "_err"}, {31'b0, b1.rsp_err}, {31'b0, exp_err});
    @(posedge clk); #1;
    check({tag, "_after_valid"}, {31'b0, b1.rsp_valid}, 32'd0);
    check({tag, "_after_rdata"}, b1.rsp_rdata, 32'd0);
    check({tag, "_after_err"}, {31'b0, b1.rsp_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_rd [3];
    logic        exp_v  [6];
    logic        exp_st [6];

    rst = 1'b0;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_size = SZ_WORD; b1.req_signed = 1'b0;
    b1.req_addr = '0; b1.req_wdata = '0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_size = SZ_WORD; b0.req_signed = 1'b0;
    b0.req_addr = '0; b0.req_wdata = '0;
    #2;
    check("rst_ready", {31'b0, b1.req_ready}, 32'd1);
    check("rst_valid", {31'b0, b1.rsp_valid}, 32'd0);
    check("rst_err", {31'b0, b1.rsp_err}, 32'd0);
    check("rst_rdata", b1.rsp_rdata, 32'd0);
    check("rst_stall", {31'b0, b1.stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    txn1("st_word",  1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn1("ld_word",  1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    txn1("st_zero",  1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    txn1("st_byte",  1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hABCDEF80, 32'h0, 1'b0);
    txn1("ld_bs",    1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
    txn1("ld_bu",    1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'h00000080, 1'b0);
    txn1("ld_w8000", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h00008000, 1'b0);
    txn1("st_half",  1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234A5C3, 32'h0, 1'b0);
    txn1("ld_hs",    1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'hFFFFA5C3, 1'b0);
    txn1("ld_hu_lo", 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'h00008000, 1'b0);
    txn1("ld_b3s",   1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0);
    txn1("ld_h_mis", 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    txn1("st_w_mis", 1'b1, SZ_WORD, 1'b0, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn1("st_ill",   1'b1, SZ_ILL,  1'b0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn1("ld_nochg", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hA5C38000, 1'b0);

    // Reset asserted while a store sits in WAIT.
    txn1("st_prior", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11111111, 32'h0, 1'b0);
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_size = SZ_WORD; b1.req_signed = 1'b0;
    b1.req_addr = 32'h20; b1.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    b1.req_valid = 1'b0;
    check("wait_ready", {31'b0, b1.req_ready}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("rstw_valid", {31'b0, b1.rsp_valid}, 32'd0);
    check("rstw_err", {31'b0, b1.rsp_err}, 32'd0);
    check("rstw_rdata", b1.rsp_rdata, 32'd0);
    check("rstw_stall", {31'b0, b1.stall}, 32'd0);
    check("rstw_ready", {31'b0, b1.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    txn1("ld_prior", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

    // Address wrap at 1024 words.
    txn1("st_wrap", 1'b1, SZ_WORD, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b0);
    txn1("ld_wrap", 1'b0, SZ_WORD, 1'b0, 32'h0000, 32'h0, 32'hCAFEF00D, 1'b0);

    // Zero-wait instance with req_valid held across three back-to-back requests.
    exp_rd = '{32'h0, 32'h0BADF00D, 32'h0000000B};
    exp_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_st = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_size = SZ_WORD; b0.req_signed = 1'b0;
    b0.req_addr = 32'h40; b0.req_wdata = 32'h0BADF00D;
    #1;
    check("z_pre_stall", {31'b0, b0.stall}, 32'd1);
    check("z_pre_valid", {31'b0, b0.rsp_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check($sformatf("z_valid_%0d", i), {31'b0, b0.rsp_valid}, {31'b0, exp_v[i]});
      check($sformatf("z_stall_%0d", i), {31'b0, b0.stall}, {31'b0, exp_st[i]});
      if (exp_v[i]) begin
        check($sformatf("z_rdata_%0d", i), b0.rsp_rdata, exp_rd[i/2]);
        check($sformatf("z_err_%0d", i), {31'b0, b0.rsp_err}, 32'd0);
      end
      if (i == 0) begin
        b0.req_we = 1'b0; b0.req_size = SZ_WORD; b0.req_addr = 32'h40; b0.req_wdata = 32'hFFFFFFFF;
      end else if (i == 2) begin
        b0.req_we = 1'b0; b0.req_size = SZ_BYTE; b0.req_signed = 1'b0; b0.req_addr = 32'h43;
      end else if (i == 4) begin
        b0.req_valid = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
